// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, data width and frame lengths.
package uart_pkg;

    localparam int UART_DATA_BITS      = 8;
    localparam int UART_FRAME_BITS_8N1 = 10;
    localparam int UART_FRAME_BITS_8E1 = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..2*CLK_PER_HALF_BIT-1, wraps, and flags terminal count.
module uart_baud_counter #(
    parameter int CLK_PER_HALF_BIT = 86
) (
    input  logic clk_uart,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(2 * CLK_PER_HALF_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = en && (cnt == TERM);

    always_ff @(posedge clk_uart) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == TERM) cnt <= '0;
            else             cnt <= cnt + 1'b1;
        end
    end

    cnt_in_range: assert property (@(posedge clk_uart) disable iff (!rstn) cnt <= TERM);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, 8 data bits LSB first, optional even parity, one stop.
// Parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 86
) (
    input  logic           clk_uart,
    input  logic           rstn,
    input  logic [7:0]     sdata,
    input  logic           tx_start,
    output logic           tx_busy,
    output logic           txd,
    output uart_tx_state_t tx_state
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    // Handshake: tx_start is a one-cycle request, accepted only in IDLE; tx_busy
    // rises on the acceptance edge and falls on the edge that ends the stop bit.
    uart_tx_state_t             state;
    logic [UART_DATA_BITS-1:0]  shift;
    logic [2:0]                 bit_idx;
    logic                       baud_clr;
    logic                       baud_tc;
`ifdef UART_TX_PARITY_EN
    logic                       parity_bit;
`endif

    assign tx_state = state;
    assign baud_clr = (state == IDLE);

    uart_baud_counter #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_baud (
        .clk_uart (clk_uart),
        .rstn     (rstn),
        .clr      (baud_clr),
        .en       (!baud_clr),
        .tc       (baud_tc)
    );

    always_ff @(posedge clk_uart) begin
        if (!rstn) begin
            state   <= IDLE;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            shift   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift   <= sdata;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= even_parity(sdata);
`endif
                        txd     <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (baud_tc) begin
                        txd   <= shift[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            txd     <= parity_bit;
                            state   <= PARITY;
`else
                            txd     <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            // shift[1] is the bit that moves into shift[0] on this edge
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[UART_DATA_BITS-1:1]};
                            txd     <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tc) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_tc) begin
                        txd     <= 1'b1;
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                    bit_idx <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    busy_tracks_state: assert property (@(posedge clk_uart) disable iff (!rstn)
        tx_busy == (state != IDLE));
    idle_line_high: assert property (@(posedge clk_uart) disable iff (!rstn)
        (state == IDLE) |-> txd);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLK_PER_HALF_BIT=4 (8-cycle bit period).
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int CPH = 4;
    localparam int P   = 2 * CPH;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = 11;
`else
    localparam int NB  = 10;
`endif

    logic           clk_uart = 1'b0;
    logic           rstn     = 1'b0;
    logic           tx_start = 1'b0;
    logic [7:0]     sdata    = 8'h00;
    logic           tx_busy;
    logic           txd;
    uart_tx_state_t tx_state;

    int errors = 0;
    int checks = 0;
    logic [0:0] exp_q[$];

    uart_tx_serializer #(.CLK_PER_HALF_BIT(CPH)) dut (
        .clk_uart (clk_uart),
        .rstn     (rstn),
        .sdata    (sdata),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .txd      (txd),
        .tx_state (tx_state)
    );

    // clock / watchdog
    always #5 clk_uart = ~clk_uart;

    initial begin
        #200000;
        $display("FAIL watchdog timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    // Expected line levels, one entry per bit period.
    task automatic build_frame(input logic [7:0] d);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    // Called #1 after an edge with the DUT idle. Sends d and checks every cycle of the
    // frame. inject_k: frame cycle in which a stray tx_start(0xFF) is driven.
    // abort_k: frame cycle in which reset is asserted (frame then abandoned).
    task automatic run_frame(input logic [7:0] d, input int inject_k, input int abort_k);
        logic [0:0] bit_v;
        int k;
        build_frame(d);
        sdata    = d;
        tx_start = 1'b1;
        @(posedge clk_uart); #1;
        tx_start = 1'b0;
        for (int b = 0; b < NB; b++) begin
            bit_v = exp_q.pop_front();
            for (int c = 0; c < P; c++) begin
                k = b * P + c;
                checks++;
                if (txd !== bit_v[0] || tx_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_bit d=%02h k=%0d txd=%b busy=%b required txd=%b busy=1",
                             d, k, txd, tx_busy, bit_v[0]);
                end
                if (k == abort_k) begin
                    tx_start = 1'b0;
                    rstn     = 1'b0;
                    @(posedge clk_uart); #1;
                    checks++;
                    if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_state !== IDLE) begin
                        errors++;
                        $display("FAIL abort_reset txd=%b busy=%b state=%0d required txd=1 busy=0 state=0",
                                 txd, tx_busy, tx_state);
                    end
                    repeat (2) @(posedge clk_uart);
                    #1 rstn = 1'b1;
                    @(posedge clk_uart); #1;
                    return;
                end
                tx_start = (k == inject_k);
                sdata    = (k == inject_k) ? 8'hFF : 8'($urandom_range(0, 255));
                @(posedge clk_uart); #1;
            end
        end
        tx_start = 1'b0;
        checks++;
        if (tx_busy !== 1'b0 || txd !== 1'b1 || tx_state !== IDLE) begin
            errors++;
            $display("FAIL frame_end d=%02h txd=%b busy=%b state=%0d required txd=1 busy=0 state=0",
                     d, txd, tx_busy, tx_state);
        end
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        tx_start = 1'b1;
        sdata    = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_uart); #1;
            checks++;
            if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_state !== IDLE) begin
                errors++;
                $display("FAIL reset cycle=%0d txd=%b busy=%b state=%0d required txd=1 busy=0 state=0",
                         i, txd, tx_busy, tx_state);
            end
        end
        tx_start = 1'b0;
        rstn     = 1'b1;
        @(posedge clk_uart); #1;
    endtask

    task automatic test_single_byte();
        run_frame(8'h55, -1, -1);
        @(posedge clk_uart); #1;
    endtask

    task automatic test_ignore_busy();
        run_frame(8'hA3, 29, -1);
        @(posedge clk_uart); #1;
        // stray start on the edge that completes STOP must not launch a frame
        run_frame(8'h3C, NB * P - 1, -1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_uart); #1;
            checks++;
            if (tx_busy !== 1'b0 || txd !== 1'b1) begin
                errors++;
                $display("FAIL stop_edge_start cycle=%0d txd=%b busy=%b required txd=1 busy=0",
                         i, txd, tx_busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_frame(8'h00, -1, -1);
        run_frame(8'hFF, -1, -1);
        @(posedge clk_uart); #1;
    endtask

    task automatic test_reset_mid_frame();
        run_frame(8'h0F, -1, 36);
        run_frame(8'h81, -1, -1);
        @(posedge clk_uart); #1;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        run_frame(8'h07, -1, -1);
        @(posedge clk_uart); #1;
        run_frame(8'h03, -1, -1);
        @(posedge clk_uart); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
